// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the ID-stage branch resolver: branch classes,
// compare-flag bus layout and the redirect FSM state encoding.
package branch_resolve_pkg;

   typedef enum logic [3:0] {
      BEQ    = 4'd0,
      BNE    = 4'd1,
      BGEZ   = 4'd2,
      BGTZ   = 4'd3,
      BLEZ   = 4'd4,
      BLTZ   = 4'd5,
      BGEZAL = 4'd6,
      BLTZAL = 4'd7,
      J      = 4'd8,
      JAL    = 4'd9,
      JR     = 4'd10,
      JALR   = 4'd11
   } br_type_e;

   // Compare-flag bus: [2] = (rs == rt), [1:0] = rs sign class
   localparam int CMP_EQ_BIT  = 2;
   localparam int CMP_SIGN_HI = 1;
   localparam int CMP_SIGN_LO = 0;

   localparam logic [1:0] POS  = 2'b00;
   localparam logic [1:0] ZERO = 2'b01;
   localparam logic [1:0] NEG  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_SLOT = 2'd1,
      S_REDIRECT  = 2'd2
   } state_e;

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition evaluation: decides taken and whether the
// instruction writes a link register.
module br_cond_eval
   import branch_resolve_pkg::*;
(
   input  logic [3:0] br_type_i,
   input  logic [2:0] cmp_flags_i,
   output logic       taken_o,
   output logic       is_link_o
);

   logic       eq;
   logic [1:0] sign;
   logic       signValid;

   assign eq        = cmp_flags_i[CMP_EQ_BIT];
   assign sign      = cmp_flags_i[CMP_SIGN_HI:CMP_SIGN_LO];
   // Sign class 11 is not a legal comparator output; conditional branches never take on it
   assign signValid = (sign != 2'b11);

   always_comb begin
      taken_o   = 1'b0;
      is_link_o = 1'b0;
      case (br_type_e'(br_type_i))
         BEQ:    taken_o = signValid && eq;
         BNE:    taken_o = signValid && !eq;
         BGTZ:   taken_o = (sign == POS);
         BLEZ:   taken_o = (sign == ZERO) || (sign == NEG);
         BGEZ:   taken_o = (sign == POS) || (sign == ZERO);
         BLTZ:   taken_o = (sign == NEG);
         BGEZAL: begin
            taken_o   = (sign == POS) || (sign == ZERO);
            is_link_o = 1'b1;
         end
         BLTZAL: begin
            taken_o   = (sign == NEG);
            is_link_o = 1'b1;
         end
         J:      taken_o = 1'b1;
         JR:     taken_o = 1'b1;
         JAL, JALR: begin
            taken_o   = 1'b1;
            is_link_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolver: turns compare flags into a registered PC redirect
// that waits for the delay slot, plus link writes and statistics counters.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int          CNT_W    = 16,
   parameter logic [4:0]  LINK_REG = 5'd31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   input  logic [3:0]       br_type,
   input  logic [2:0]       cmp_flags,
   input  logic [31:0]      pc_id,
   input  logic [15:0]      imm16,
   input  logic [25:0]      instr_index,
   input  logic [31:0]      rs_value,
   input  logic [4:0]       rd_idx,
   input  logic             stall,
   input  logic             slot_fetched,
   input  logic             flush,
   output logic             busy,
   output logic             pc_redirect,
   output logic [31:0]      redirect_pc,
   output logic             link_we,
   output logic [4:0]       link_idx,
   output logic [31:0]      link_data,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   state_e            state_q, state_d;
   logic [31:0]       target_q;
   logic              link_we_q, link_we_d;
   logic [4:0]        link_idx_q;
   logic [31:0]       link_data_q;
   logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q;

   logic              accept;
   logic              condTaken;
   logic              condLink;
   logic              isJalr;
   logic [31:0]       pcPlus4;
   logic [31:0]       brOffset;
   logic [31:0]       targetNext;

   br_cond_eval u_cond (
      .br_type_i   (br_type),
      .cmp_flags_i (cmp_flags),
      .taken_o     (condTaken),
      .is_link_o   (condLink)
   );

   // A flush on the same cycle wins over the incoming branch
   assign accept   = br_valid && !stall && (state_q == S_IDLE) && !flush;
   assign isJalr   = (br_type == JALR);
   assign pcPlus4  = pc_id + 32'd4;
   assign brOffset = {{14{imm16[15]}}, imm16, 2'b00};

   always_comb begin
      case (br_type_e'(br_type))
         J, JAL:   targetNext = {pcPlus4[31:28], instr_index, 2'b00};
         JR, JALR: targetNext = rs_value;
         default:  targetNext = pcPlus4 + brOffset;
      endcase
   end

   // Link happens whether or not the branch is taken; JALR to r0 is a no-op write
   assign link_we_d = accept && condLink && !(isJalr && (rd_idx == 5'd0));

   always_comb begin
      state_d     = state_q;
      pc_redirect = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && condTaken) begin
               state_d = slot_fetched ? S_REDIRECT : S_WAIT_SLOT;
            end
         end
         S_WAIT_SLOT: begin
            if (slot_fetched) begin
               state_d = S_REDIRECT;
            end
         end
         S_REDIRECT: begin
            pc_redirect = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d     = S_IDLE;
         pc_redirect = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         target_q    <= 32'd0;
         link_we_q   <= 1'b0;
         link_idx_q  <= 5'd0;
         link_data_q <= 32'd0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         link_we_q <= link_we_d;
         if (accept && condTaken) begin
            target_q <= targetNext;
         end
         if (link_we_d) begin
            link_idx_q  <= isJalr ? rd_idx : LINK_REG;
            link_data_q <= pc_id + 32'd8;
         end
         // Counters stick at all-ones rather than wrapping
         if (accept && (br_cnt_q != '1)) begin
            br_cnt_q <= br_cnt_q + CNT_W'(1);
         end
         if (accept && condTaken && (taken_cnt_q != '1)) begin
            taken_cnt_q <= taken_cnt_q + CNT_W'(1);
         end
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign redirect_pc = target_q;
   assign link_we     = link_we_q;
   assign link_idx    = link_idx_q;
   assign link_data   = link_data_q;
   assign br_cnt      = br_cnt_q;
   assign taken_cnt   = taken_cnt_q;

endmodule
